// File: rtl/seg7_pkg.sv
// seg7_pkg: shared FSM state type, hex-to-segment table and anode constant for the seg7 scanner.
package seg7_pkg;
  typedef enum logic {BLANK = 1'b0, SHOW = 1'b1} state_e;
  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// seg7_scan_ctrl_if: value load strobe, enables and scanned display outputs of seg7_scan_ctrl.
interface seg7_scan_ctrl_if;
  logic [15:0] val;
  logic        load;
  logic [3:0]  dp_in;
  logic [3:0]  en;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        upd;
  modport master (output val, load, dp_in, en, input an, seg, dp, upd);
  modport slave (input val, load, dp_in, en, output an, seg, dp, upd);
endinterface

// File: rtl/seg7_hex_dec.sv
// seg7_hex_dec: combinational 4-bit nibble to {g,f,e,d,c,b,a} segment decoder.
module seg7_hex_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);
  assign seg_o = HEX_SEG[nib_i];
endmodule

// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl: 4-digit multiplexed 7-segment scanner with frame-synchronous, tear-free value updates.
// Define SEG7_LZB_EN to blank leading zeros on digits 3..1.
module seg7_scan_ctrl
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input logic clk,
  input logic rst,
  seg7_scan_ctrl_if.slave bus
);
  localparam int MX = REFRESH_DIV > BLANK_CYC ? REFRESH_DIV : BLANK_CYC;
  localparam int CW = $clog2(MX + 1);
  state_e state_q, state_d;
  logic [1:0] dix_q, dix_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0] disp_q, disp_d, pend_q, pend_d;
  logic [3:0] dpd_q, dpd_d, pdp_q, pdp_d;
  logic pv_q, pv_d;
  logic [3:0] an_q, an_d;
  logic [6:0] seg_q, seg_d, dec;
  logic dp_q, dp_d, upd_q, upd_d;
  logic last, bnd, lit;
  logic [3:0] dark;
  // Outputs are registered from next-state values so they line up with the state they describe.
  seg7_hex_dec u_dec (.nib_i(disp_q[{dix_d, 2'b00} +: 4]), .seg_o(dec));
  always_comb begin
    last    = state_q == SHOW ? cnt_q == CW'(REFRESH_DIV - 1) : cnt_q == CW'(BLANK_CYC - 1);
    bnd     = last && state_q == SHOW && dix_q == 2'd3;
    state_d = last ? (state_q == SHOW ? BLANK : SHOW) : state_q;
    dix_d   = last && state_q == SHOW ? dix_q + 2'd1 : dix_q;
    cnt_d   = last ? '0 : cnt_q + 1'b1;
    pend_d  = bus.load ? bus.val : pend_q;
    pdp_d   = bus.load ? bus.dp_in : pdp_q;
    pv_d    = !bnd && (bus.load || pv_q);
    disp_d  = bnd ? (bus.load ? bus.val : (pv_q ? pend_q : disp_q)) : disp_q;
    dpd_d   = bnd ? (bus.load ? bus.dp_in : (pv_q ? pdp_q : dpd_q)) : dpd_q;
    upd_d   = bnd && (bus.load || pv_q);
`ifdef SEG7_LZB_EN
    dark[3] = disp_q[15:12] == 4'h0;
    dark[2] = dark[3] && disp_q[11:8] == 4'h0;
    dark[1] = dark[2] && disp_q[7:4] == 4'h0;
    dark[0] = 1'b0;
`else
    dark    = '0;
`endif
    lit     = state_d == SHOW && bus.en[dix_d] && !dark[dix_d];
    an_d    = lit ? ~(4'b0001 << dix_d) : ANODE_OFF;
    seg_d   = lit ? dec : '0;
    dp_d    = lit && dpd_q[dix_d];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= BLANK;
      dix_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      dpd_q   <= '0;
      pend_q  <= '0;
      pdp_q   <= '0;
      pv_q    <= 1'b0;
      an_q    <= ANODE_OFF;
      seg_q   <= '0;
      dp_q    <= 1'b0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dix_q   <= dix_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      dpd_q   <= dpd_d;
      pend_q  <= pend_d;
      pdp_q   <= pdp_d;
      pv_q    <= pv_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      upd_q   <= upd_d;
    end
  end
  assign bus.an  = an_q;
  assign bus.seg = seg_q;
  assign bus.dp  = dp_q;
  assign bus.upd = upd_q;
endmodule
